// File: rtl/sc_sng_scheduler_if.sv
// rtl/sc_sng_scheduler_if.sv - request/stream bundle for the shared SNG scheduler
// Purpose: groups the requester handshake, seed load, output stream and status
//          signals of sc_sng_scheduler into one bundle.
// Signals:
//   req_valid  [NUM_REQ]    request i pending, held until acknowledged
//   req_value  [4*NUM_REQ]  probability of requester i in [4i+3:4i]
//   req_ack    [NUM_REQ]    one-hot grant pulse
//   seed_load, seed_value   LFSR seed load (honoured while idle)
//   out_valid, out_ready    stream beat handshake
//   out_bits   [4]          stream bits, bit0 earliest
//   out_id     [ID_W]       granted requester
//   out_last                final beat of the stream
//   busy                    scheduler is streaming
// Modports: master = requesters/consumer side, slave = scheduler side.
interface sc_sng_scheduler_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]   req_valid;
   logic [4*NUM_REQ-1:0] req_value;
   logic [NUM_REQ-1:0]   req_ack;
   logic                 seed_load;
   logic [3:0]           seed_value;
   logic                 out_valid;
   logic                 out_ready;
   logic [3:0]           out_bits;
   logic [ID_W-1:0]      out_id;
   logic                 out_last;
   logic                 busy;

   modport master (
      output req_valid, req_value, seed_load, seed_value, out_ready,
      input  req_ack, out_valid, out_bits, out_id, out_last, busy
   );

   modport slave (
      input  req_valid, req_value, seed_load, seed_value, out_ready,
      output req_ack, out_valid, out_bits, out_id, out_last, busy
   );
endinterface

// File: rtl/sc_sng_scheduler.sv
// rtl/sc_sng_scheduler.sv - round-robin shared stochastic number generator
// Purpose: owns one 4-bit LFSR (x^4+x^3+1) advanced 4 steps per beat and
//          grants it round-robin to NUM_REQ requesters, turning the granted
//          4-bit probability into a STREAM_LEN-bit unipolar bitstream.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    sc_sng_scheduler_if.slave (requests, seed load, stream, busy)
module sc_sng_scheduler #(
   parameter int         NUM_REQ    = 4,
   parameter logic [3:0] SEED       = 4'b0001,
   parameter int         STREAM_LEN = 16
) (
   input logic               clk,
   input logic               reset,
   sc_sng_scheduler_if.slave bus
);
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BEATS = STREAM_LEN / 4;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [3:0]       lfsr, val_q;
   logic [ID_W-1:0]  rr_ptr, id_q, grant_idx;
   logic [CNT_W-1:0] beat_cnt;
   logic             grant_hit, grant_go, last_beat;
   logic [NUM_REQ-1:0] ack;
   logic [3:0]       r1, r2, r3, r4, bits;

   function automatic logic [3:0] lfsr_step(input logic [3:0] s);
      return {s[2:0], s[3] ^ s[2]};
   endfunction

   // Four chained steps: each output bit is compared against its own nibble,
   // and r4 becomes the next LFSR state once the beat is accepted.
   always_comb begin
      r1   = lfsr_step(lfsr);
      r2   = lfsr_step(r1);
      r3   = lfsr_step(r2);
      r4   = lfsr_step(r3);
      bits = {val_q > r4, val_q > r3, val_q > r2, val_q > r1};
   end

   // Rotating-priority search: first pending request at or above rr_ptr,
   // wrapping at NUM_REQ.
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_hit && bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
            grant_hit = 1'b1;
            grant_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
         end
      end
   end

   assign last_beat = (beat_cnt == LAST_BEAT);

   // A seed load in the same idle cycle suppresses the grant; reset also
   // masks it so req_ack reads 0 while reset is held.
   assign grant_go = (state == IDLE) && !reset && !bus.seed_load && grant_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ack       = '0;
      case (state)
         IDLE: begin
            if (grant_go) begin
               ack[grant_idx] = 1'b1;
               state_nxt      = RUN;
            end
         end
         RUN: begin
            if (bus.out_ready && last_beat) state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr     <= SEED;
         val_q    <= '0;
         id_q     <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else if (state == IDLE) begin
         if (bus.seed_load) begin
            // an all-zero seed would lock the LFSR, so fall back to SEED
            lfsr <= (bus.seed_value == 4'd0) ? SEED : bus.seed_value;
         end else if (grant_hit) begin
            val_q    <= bus.req_value[4*grant_idx +: 4];
            id_q     <= grant_idx;
            beat_cnt <= '0;
         end
      end else if (bus.out_ready) begin
         lfsr     <= r4;
         beat_cnt <= beat_cnt + 1'b1;
         if (last_beat) rr_ptr <= ID_W'((int'(id_q) + 1) % NUM_REQ);
      end
   end

   assign bus.req_ack   = ack;
   assign bus.out_valid = (state == RUN);
   assign bus.out_bits  = (state == RUN) ? bits : 4'd0;
   assign bus.out_last  = (state == RUN) && last_beat;
   assign bus.out_id    = id_q;
   assign bus.busy      = (state == RUN);
endmodule
